global_mem_rd_streamer: RTL and testbench

- Read-side counterpart to the global memory writer. It drives port B of the 1024x18 global-memory LSRAM in the MAC clock domain.
- On a start command it reads a contiguous, wrapping range of words. It absorbs the fixed RAM read latency and streams the words in order to the MAC core feeder over a valid/ready interface.
- A credit-limited output FIFO guarantees that no in-flight read is lost under backpressure.

---
 rtl/global_mem_rd_streamer.sv | 181 ++++++++++++++++++
 tb/tb_global_mem_rd_streamer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/global_mem_rd_streamer.sv
// global_mem_rd_streamer
//
// Read side of the global-memory LSRAM (port B, MAC clock domain). A start
// command reads a contiguous range of words, wrapping at the 1024-word
// boundary. The block absorbs the RAM's pipelined read latency and streams the
// words, in address order, to the MAC core feeder over valid/ready.
//
// Reads are credit-limited: a read issues only while
// (reads in flight + FIFO occupancy) < FIFO_DEPTH. Every returning word
// therefore has a FIFO slot, however long the consumer stalls.
//
// Ports
//   macclk       clock, rising edge
//   rst          synchronous active-high reset
//   i_start      one-cycle start command, accepted while the FSM is idle
//   i_base_addr  first word address
//   i_len        word count, 0..1024
//   o_busy       high from the cycle after an accepted start to the o_done cycle
//   o_done       one-cycle pulse after the last word is accepted downstream
//   o_mem_addr   LSRAM port B address, {word_addr, 1'b0} in x18 mode
//   o_mem_ren    LSRAM port B read enable
//   i_mem_dout   LSRAM port B read data, valid RD_LAT cycles after o_mem_ren
//   o_data       stream data (FIFO head)
//   o_valid      stream valid (FIFO non-empty)
//   i_ready      stream ready
module global_mem_rd_streamer #(
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_W     = 18
) (
  input  logic              macclk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [9:0]        i_base_addr,
  input  logic [10:0]       i_len,
  output logic              o_busy,
  output logic              o_done,
  output logic [10:0]       o_mem_addr,
  output logic              o_mem_ren,
  input  logic [DATA_W-1:0] i_mem_dout,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // Wide enough for inflight + fifo count, whose sum never exceeds FIFO_DEPTH.
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + RD_LAT + 1);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } state_e;

  state_e            state_q;
  logic [9:0]        base_q;
  logic [10:0]       len_q;
  logic [10:0]       issued_q;
  logic [10:0]       accepted_q;
  logic              busy_q;
  logic              done_q;

  // One bit per outstanding read; bit RD_LAT-1 marks the word on i_mem_dout.
  logic [RD_LAT-1:0] inflight_sr_q;

  logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [CntW-1:0]   fifo_cnt_q;

  logic [CntW-1:0]   inflight;
  logic [CntW-1:0]   occupancy;
  logic              issue_en;
  logic [9:0]        word_addr;
  logic              fifo_wr;
  logic              fifo_rd;

  // Derived purely from registers, so no input reaches an output combinationally.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CntW'(inflight_sr_q[i]);
    end
    occupancy = inflight + fifo_cnt_q;
    issue_en  = (state_q == StIssue) && (issued_q < len_q) &&
                (occupancy < CntW'(FIFO_DEPTH));
    // 10-bit add wraps 1023 -> 0.
    word_addr = base_q + issued_q[9:0];
    fifo_wr   = inflight_sr_q[RD_LAT-1];
    fifo_rd   = (fifo_cnt_q != '0) && i_ready;
  end

  assign o_mem_ren  = issue_en;
  assign o_mem_addr = issue_en ? {word_addr, 1'b0} : '0;
  assign o_valid    = (fifo_cnt_q != '0);
  assign o_data     = o_valid ? fifo_mem_q[rd_ptr_q] : '0;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

  // FIFO storage needs no reset: o_data is masked while the FIFO is empty.
  always_ff @(posedge macclk) begin
    if (fifo_wr && !rst) begin
      fifo_mem_q[wr_ptr_q] <= i_mem_dout;
    end
  end

  always_ff @(posedge macclk) begin
    if (rst) begin
      state_q       <= StIdle;
      base_q        <= '0;
      len_q         <= '0;
      issued_q      <= '0;
      accepted_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      inflight_sr_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;

      // Read-latency tracker.
      inflight_sr_q[0] <= issue_en;
      for (int i = 1; i < RD_LAT; i++) begin
        inflight_sr_q[i] <= inflight_sr_q[i-1];
      end

      // FIFO pointers and occupancy; simultaneous write and read cancel out.
      if (fifo_wr) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (fifo_rd) begin
        rd_ptr_q   <= rd_ptr_q + PtrW'(1);
        accepted_q <= accepted_q + 11'd1;
      end
      case ({fifo_wr, fifo_rd})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CntW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CntW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase

      if (issue_en) begin
        issued_q <= issued_q + 11'd1;
      end

      unique case (state_q)
        StIdle: begin
          // Also the o_done cycle: busy falls here unless a new job starts.
          busy_q <= 1'b0;
          if (i_start) begin
            if (i_len != 11'd0) begin
              base_q     <= i_base_addr;
              len_q      <= i_len;
              issued_q   <= '0;
              accepted_q <= '0;
              busy_q     <= 1'b1;
              state_q    <= StIssue;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        StIssue: begin
          if (issue_en && (issued_q + 11'd1 == len_q)) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if ((inflight == '0) && fifo_rd && (accepted_q + 11'd1 == len_q)) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_global_mem_rd_streamer.sv
// Bench for global_mem_rd_streamer: a behavioural LSRAM with pipelined read
// data, a scoreboard of expected addresses/words per job built from
// (base + k) mod 1024, and directed plus randomized jobs.
module tb_global_mem_rd_streamer;

  localparam int unsigned RD_LAT     = 2;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned DATA_W     = 18;

  logic              macclk = 1'b0;
  logic              rst = 1'b1;
  logic              i_start = 1'b0;
  logic [9:0]        i_base_addr = '0;
  logic [10:0]       i_len = '0;
  logic              o_busy;
  logic              o_done;
  logic [10:0]       o_mem_addr;
  logic              o_mem_ren;
  logic [DATA_W-1:0] i_mem_dout;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              i_ready = 1'b1;

  global_mem_rd_streamer #(
    .RD_LAT    (RD_LAT),
    .FIFO_DEPTH(FIFO_DEPTH),
    .DATA_W    (DATA_W)
  ) dut (
    .macclk     (macclk),
    .rst        (rst),
    .i_start    (i_start),
    .i_base_addr(i_base_addr),
    .i_len      (i_len),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_mem_addr (o_mem_addr),
    .o_mem_ren  (o_mem_ren),
    .i_mem_dout (i_mem_dout),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready)
  );

  always #5 macclk = ~macclk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural LSRAM: word k holds k + 0x100; read data appears RD_LAT later.
  logic [DATA_W-1:0] mem [1024];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = DATA_W'(k + 'h100);
  end
  always @(posedge macclk) begin
    rd_pipe[0] <= o_mem_ren ? mem[o_mem_addr[10:1]] : '1;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign i_mem_dout = rd_pipe[RD_LAT-1];

  // Ready pattern: 0 = always ready, 1 = random 50 %, 2 = stalled.
  int ready_mode = 0;
  initial begin
    forever begin
      @(posedge macclk);
      #1;
      if (ready_mode == 0)      i_ready = 1'b1;
      else if (ready_mode == 1) i_ready = 1'($urandom_range(0, 1));
      else                      i_ready = 1'b0;
    end
  end

  // Scoreboard.
  logic [9:0]        exp_addr [$];
  logic [DATA_W-1:0] exp_data [$];
  int ren_total = 0;
  int acc_total = 0;
  int done_cnt  = 0;

  always @(negedge macclk) begin
    if (rst) begin
      exp_addr.delete();
      exp_data.delete();
      ren_total = 0;
      acc_total = 0;
    end else begin
      if (o_mem_ren) begin
        // Outstanding reads before this one must leave room for it.
        check("credit", 32'((ren_total - acc_total) < int'(FIFO_DEPTH)), 32'd1);
        check("ren_expected", 32'(exp_addr.size() > 0), 32'd1);
        if (exp_addr.size() > 0) begin
          check("mem_addr", 32'(o_mem_addr), 32'({exp_addr.pop_front(), 1'b0}));
        end
        ren_total++;
      end
      if (o_valid && i_ready) begin
        check("beat_expected", 32'(exp_data.size() > 0), 32'd1);
        if (exp_data.size() > 0) begin
          check("data", 32'(o_data), 32'(exp_data.pop_front()));
        end
        acc_total++;
      end
      if (o_done) done_cnt++;
    end
  end

  task automatic start_job(input logic [9:0] base, input logic [10:0] len);
    @(posedge macclk);
    #1;
    i_start     = 1'b1;
    i_base_addr = base;
    i_len       = len;
    for (int k = 0; k < int'(len); k++) begin
      exp_addr.push_back(10'((int'(base) + k) % 1024));
      exp_data.push_back(mem[(int'(base) + k) % 1024]);
    end
    @(posedge macclk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic finish_job(input int d0, input int a0, input int len, input int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge macclk);
      n++;
    end
    check("done_seen", 32'(done_cnt != d0), 32'd1);
    repeat (3) @(posedge macclk);
    check("done_once", 32'(done_cnt - d0), 32'd1);
    check("beats", 32'(acc_total - a0), 32'(len));
    check("left_over", 32'(exp_data.size()), 32'd0);
    exp_addr.delete();
    exp_data.delete();
  endtask

  task automatic run_job(input logic [9:0] base, input logic [10:0] len, input int budget);
    int d0 = done_cnt;
    int a0 = acc_total;
    start_job(base, len);
    finish_job(d0, a0, int'(len), budget);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    int a0;
    int r0;

    // Reset values.
    repeat (2) @(posedge macclk);
    @(negedge macclk);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_ren", 32'(o_mem_ren), 32'd0);
    check("rst_addr", 32'(o_mem_addr), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    @(posedge macclk);
    #1;
    rst = 1'b0;

    // Basic, cycle-exact: start in cycle 0.
    d0 = done_cnt;
    a0 = acc_total;
    start_job(10'h010, 11'd4);
    for (int c = 1; c <= 9; c++) begin
      @(negedge macclk);
      check("b_ren", 32'(o_mem_ren), 32'(c >= 1 && c <= 4));
      if (c <= 4) check("b_addr", 32'(o_mem_addr), 32'('h20 + 2 * (c - 1)));
      check("b_valid", 32'(o_valid), 32'(c >= 4 && c <= 7));
      if (c >= 4 && c <= 7) check("b_data", 32'(o_data), 32'('h110 + c - 4));
      check("b_done", 32'(o_done), 32'(c == 8));
      check("b_busy", 32'(o_busy), 32'(c >= 1 && c <= 8));
    end
    finish_job(d0, a0, 4, 20);

    // Backpressure: consumer stalled, only FIFO_DEPTH reads may issue.
    ready_mode = 2;
    @(posedge macclk);
    d0 = done_cnt;
    a0 = acc_total;
    r0 = ren_total;
    start_job(10'h010, 11'd16);
    repeat (9) @(posedge macclk);
    check("bp_reads", 32'(ren_total - r0), 32'(FIFO_DEPTH));
    ready_mode = 0;
    finish_job(d0, a0, 16, 200);

    // Address wrap.
    run_job(10'd1022, 11'd4, 50);

    // len = 0: immediate done, no reads, never busy.
    d0 = done_cnt;
    a0 = acc_total;
    r0 = ren_total;
    start_job(10'h055, 11'd0);
    @(negedge macclk);
    check("z_done", 32'(o_done), 32'd1);
    check("z_busy", 32'(o_busy), 32'd0);
    check("z_ren", 32'(o_mem_ren), 32'd0);
    @(negedge macclk);
    check("z_done_pulse", 32'(o_done), 32'd0);
    check("z_busy2", 32'(o_busy), 32'd0);
    finish_job(d0, a0, 0, 20);
    check("z_no_reads", 32'(ren_total - r0), 32'd0);

    // Second start while busy is ignored.
    d0 = done_cnt;
    a0 = acc_total;
    start_job(10'h200, 11'd8);
    @(posedge macclk);
    #1;
    check("ign_busy", 32'(o_busy), 32'd1);
    i_start     = 1'b1;
    i_base_addr = 10'h300;
    i_len       = 11'd5;
    @(posedge macclk);
    #1;
    i_start = 1'b0;
    finish_job(d0, a0, 8, 100);

    // Full 1024-word job with wrap back onto the base.
    run_job(10'($urandom_range(0, 1023)), 11'd1024, 1300);

    // Reset with 2 reads in flight and 2 words buffered.
    ready_mode = 2;
    @(posedge macclk);
    start_job(10'h010, 11'd16);
    repeat (4) @(posedge macclk);
    #1;
    rst = 1'b1;
    @(posedge macclk);
    #1;
    rst = 1'b0;
    ready_mode = 0;
    @(negedge macclk);
    check("r_valid", 32'(o_valid), 32'd0);
    check("r_ren", 32'(o_mem_ren), 32'd0);
    check("r_busy", 32'(o_busy), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge macclk);
      check("r_late_valid", 32'(o_valid), 32'd0);
    end
    run_job(10'h123, 11'd6, 50);

    // Random ready, long job.
    ready_mode = 1;
    run_job(10'($urandom_range(0, 1023)), 11'd200, 2000);

    // A few short random jobs.
    for (int j = 0; j < 4; j++) begin
      run_job(10'($urandom_range(0, 1023)), 11'($urandom_range(1, 40)), 500);
    end
    ready_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
